// File: rtl/pwm_pipe_ctrl.sv
// rtl/pwm_pipe_ctrl.sv - PWM sequencer: operand reads, pipe valid/address tracking, result writes
// Optional feature macro: PWM_ACC_EN (accumulate mode: wr_data = (mul_result + acc_rdata) mod Q)
module pwm_pipe_ctrl #(
  parameter int          N       = 256,
  parameter int          ADDR_W  = 8,
  parameter int          MUL_LAT = 8,
  parameter logic [22:0] PARAM_Q = 23'd8380417
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_rd_en,
  output logic [ADDR_W-1:0] o_rd_addr,
  input  logic [22:0]       i_a_rdata,
  input  logic [22:0]       i_b_rdata,
  output logic [22:0]       o_mul_opt1,
  output logic [22:0]       o_mul_opt2,
  input  logic [22:0]       i_mul_result,
`ifdef PWM_ACC_EN
  input  logic              i_acc_mode,
  output logic [ADDR_W-1:0] o_acc_rd_addr,
  input  logic [22:0]       i_acc_rdata,
`endif
  output logic              o_wr_en,
  output logic [ADDR_W-1:0] o_wr_addr,
  output logic [22:0]       o_wr_data
);

  // Tracking depth: read latency (1) + operand register (1) + pipe latency.
  localparam int DEPTH = 2 + MUL_LAT;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(N - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_FIN} state_t;

  state_t              r_state;
  logic                r_busy;
  logic                r_done;
  logic                r_rd_en;
  logic [ADDR_W-1:0]   r_rd_addr;
  logic [22:0]         r_opt1;
  logic [22:0]         r_opt2;
  logic [DEPTH-1:0]    r_vld;
  logic [ADDR_W-1:0]   r_tag [DEPTH];
  logic                r_wr_en;
  logic [ADDR_W-1:0]   r_wr_addr;
  logic [22:0]         r_wr_data;
  logic [22:0]         w_buf_data;

  // Sequencer: issues N reads back to back, then waits for the last write to leave the buffer.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= S_IDLE;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_rd_en   <= 1'b0;
      r_rd_addr <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (i_start) begin
            r_state   <= S_RUN;
            r_busy    <= 1'b1;
            r_rd_en   <= 1'b1;
            r_rd_addr <= '0;
          end
        end
        S_RUN: begin
          if (r_rd_addr == LAST) begin
            r_rd_en <= 1'b0;
            r_state <= S_DRAIN;
          end else begin
            r_rd_addr <= r_rd_addr + 1'b1;
          end
        end
        S_DRAIN: begin
          // The final write is on the outputs this cycle and nothing is left in flight.
          if (r_wr_en && (r_wr_addr == LAST) && !(|r_vld)) begin
            r_state <= S_FIN;
            r_done  <= 1'b1;
          end
        end
        S_FIN: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Valid/address shift register; the last stage lines up with i_mul_result.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_vld <= '0;
      for (int i = 0; i < DEPTH; i++) r_tag[i] <= '0;
    end else begin
      r_vld    <= {r_vld[DEPTH-2:0], r_rd_en};
      r_tag[0] <= r_rd_addr;
      for (int i = 1; i < DEPTH; i++) r_tag[i] <= r_tag[i-1];
    end
  end

  // Operand stage: capture memory data the cycle it is valid, hold otherwise.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_opt1 <= '0;
      r_opt2 <= '0;
    end else if (r_vld[0]) begin
      r_opt1 <= i_a_rdata;
      r_opt2 <= i_b_rdata;
    end
  end

`ifdef PWM_ACC_EN
  logic [23:0] w_sum;
  logic [22:0] w_acc_data;

  // Accumulator read is issued one cycle ahead so its data meets the pipe result.
  assign o_acc_rd_addr = r_tag[DEPTH-2];

  // Modular add of the product and the accumulator word; both inputs are below Q.
  always_comb begin
    w_sum      = {1'b0, i_mul_result} + {1'b0, i_acc_rdata};
    w_acc_data = w_sum[22:0];
    if (w_sum >= {1'b0, PARAM_Q}) w_acc_data = 23'(w_sum - {1'b0, PARAM_Q});
    w_buf_data = i_acc_mode ? w_acc_data : i_mul_result;
  end
`else
  assign w_buf_data = i_mul_result;
`endif

  // Output buffer: only tagged-valid slots load data and raise the write strobe.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_en   <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
    end else begin
      r_wr_en <= r_vld[DEPTH-1];
      if (r_vld[DEPTH-1]) begin
        r_wr_addr <= r_tag[DEPTH-1];
        r_wr_data <= w_buf_data;
      end
    end
  end

  assign o_busy     = r_busy;
  assign o_done     = r_done;
  assign o_rd_en    = r_rd_en;
  assign o_rd_addr  = r_rd_addr;
  assign o_mul_opt1 = r_opt1;
  assign o_mul_opt2 = r_opt2;
  assign o_wr_en    = r_wr_en;
  assign o_wr_addr  = r_wr_addr;
  assign o_wr_data  = r_wr_data;

endmodule
